// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Definitions shared by the ALU sequencer and its register file:
//   default datapath/register-index widths, the alucont opcode encodings,
//   the sequencer state enumeration and small opcode-classification helpers.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  // Default datapath width and register-index width (2^REGBITS registers).
  localparam int ALU_SEQ_WIDTH   = 16;
  localparam int ALU_SEQ_REGBITS = 4;

  // alucont opcode encodings understood by the external ALU.
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;

  // Instruction sequencing: accept -> read operands -> execute -> write back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // True for every opcode the sequencer knows how to commit.
  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  // CMP only updates flags; every other legal op writes its destination.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return op_is_legal(op) && (op != OP_CMP);
  endfunction

  // Only the arithmetic ops publish the ALU flags to the architectural psr.
  function automatic logic op_writes_psr(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_CMP: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// ---------------------------------------------------------------------------
// alu_seq_regfile
//   2^REGBITS x WIDTH register file for the ALU sequencer.
//   Ports:
//     clk, reset_n          - clock, asynchronous active-low reset (clears all)
//     rd_addr_a / rd_data_a - combinational read port A (source operand)
//     rd_addr_b / rd_data_b - combinational read port B (destination operand)
//     dbg_addr  / dbg_data  - combinational debug read port
//     wr_en, wr_addr, wr_data - synchronous write port
// ---------------------------------------------------------------------------
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = ALU_SEQ_WIDTH,
  parameter int REGBITS = ALU_SEQ_REGBITS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [REGBITS-1:0] rd_addr_a,
  output logic [WIDTH-1:0]   rd_data_a,
  input  logic [REGBITS-1:0] rd_addr_b,
  output logic [WIDTH-1:0]   rd_data_b,
  input  logic [REGBITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]   dbg_data,
  input  logic               wr_en,
  input  logic [REGBITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data
);

  localparam int NREGS = 2 ** REGBITS;

  // Flip-flop storage: reset must clear every entry at once, which rules
  // out block RAM here.
  logic [WIDTH-1:0] regs [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [WIDTH-1:0] value_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        value_reg <= '0;
      end else if (wr_en && (wr_addr == REGBITS'(gi))) begin
        value_reg <= wr_data;
      end
    end

    assign regs[gi] = value_reg;
  end

  // All reads are combinational; a write becomes visible the cycle after
  // the edge that performs it.
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Four-cycle instruction sequencer around an external combinational ALU.
//   Each accepted instruction reads its operands from the register file,
//   drives them to the ALU, samples the ALU result/flags and commits them.
//   Ports:
//     clk, reset_n            - clock, asynchronous active-low reset
//     instr_valid/instr_ready - instruction handshake (ready only when idle)
//     instr_op                - alucont opcode
//     instr_src, instr_dst    - source / destination register indices
//     instr_imm_en, instr_imm - use sign-extended 8-bit immediate as operand A
//     alu_a, alu_b, alu_cont  - registered operands/opcode to the ALU
//     alu_result, alu_psr     - combinational ALU outputs
//     psr                     - architectural status register
//     done, illegal           - one-cycle completion pulse / unsupported op
//     dbg_addr, dbg_data      - combinational register-file peek
//   Requires WIDTH >= 8 (the immediate is sign-extended to WIDTH).
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = ALU_SEQ_WIDTH,
  parameter int REGBITS = ALU_SEQ_REGBITS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [3:0]         instr_op,
  input  logic [REGBITS-1:0] instr_src,
  input  logic [REGBITS-1:0] instr_dst,
  input  logic               instr_imm_en,
  input  logic [7:0]         instr_imm,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_cont,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [7:0]         alu_psr,
  output logic [7:0]         psr,
  output logic               done,
  output logic               illegal,
  input  logic [REGBITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);

  state_t state_reg;
  state_t state_next;

  // Captured instruction fields (held for the whole instruction so that
  // later changes on instr_* cannot affect it).
  logic [3:0]         op_reg;
  logic [REGBITS-1:0] src_reg;
  logic [REGBITS-1:0] dst_reg;
  logic               imm_en_reg;
  logic [7:0]         imm_reg;

  // ALU return values sampled at the end of EXEC.
  logic [WIDTH-1:0]   result_reg;
  logic [7:0]         flags_reg;

  // Register-file plumbing.
  logic [WIDTH-1:0]   src_data;
  logic [WIDTH-1:0]   dst_data;
  logic [WIDTH-1:0]   imm_ext;
  logic               rf_wr_en;
  logic               psr_wr_en;

  assign imm_ext = WIDTH'($signed(imm_reg));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and decoded controls. done/illegal and the commit enables are
  // decodes of the registered state, so reset clears them immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    rf_wr_en    = 1'b0;
    psr_wr_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_WB;
      end
      ST_WB: begin
        done       = 1'b1;
        illegal    = !op_is_legal(op_reg);
        rf_wr_en   = op_writes_reg(op_reg);
        psr_wr_en  = op_writes_psr(op_reg);
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Instruction capture on acceptance
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg     <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      imm_en_reg <= 1'b0;
      imm_reg    <= '0;
    end else if ((state_reg == ST_IDLE) && instr_valid) begin
      op_reg     <= instr_op;
      src_reg    <= instr_src;
      dst_reg    <= instr_dst;
      imm_en_reg <= instr_imm_en;
      imm_reg    <= instr_imm;
    end
  end

  // -------------------------------------------------------------------------
  // ALU drive: loaded once per instruction (end of READ) and held until the
  // next instruction's READ, so the external ALU sees stable inputs.
  // When src == dst both operands come from the same pre-commit value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cont <= '0;
    end else if (state_reg == ST_READ) begin
      alu_a    <= imm_en_reg ? imm_ext : src_data;
      alu_b    <= dst_data;
      alu_cont <= op_reg;
    end
  end

  // -------------------------------------------------------------------------
  // ALU sample at the end of EXEC
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_reg <= '0;
      flags_reg  <= '0;
    end else if (state_reg == ST_EXEC) begin
      result_reg <= alu_result;
      flags_reg  <= alu_psr;
    end
  end

  // -------------------------------------------------------------------------
  // Architectural status register (written at the WB -> IDLE edge)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr <= '0;
    end else if (psr_wr_en) begin
      psr <= flags_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Register file; its write port commits the held result at WB -> IDLE.
  // -------------------------------------------------------------------------
  alu_seq_regfile #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr_a (src_reg),
    .rd_data_a (src_data),
    .rd_addr_b (dst_reg),
    .rd_data_b (dst_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_en     (rf_wr_en),
    .wr_addr   (dst_reg),
    .wr_data   (result_reg)
  );

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq. Provides a combinational ALU model and
//   keeps an architectural reference (register array + psr) updated per
//   instruction from the opcode rules.
//   ALU flag layout used by the model: psr[7]=N, [6]=Z, [5]=C, [4]=V.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W  = 16;
  localparam int RB = 4;
  localparam int NR = 16;

  logic          clk;
  logic          reset_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [RB-1:0] instr_src;
  logic [RB-1:0] instr_dst;
  logic          instr_imm_en;
  logic [7:0]    instr_imm;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_cont;
  logic [W-1:0]  alu_result;
  logic [7:0]    alu_psr;
  logic [7:0]    psr;
  logic          done;
  logic          illegal;
  logic [RB-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  logic [W-1:0] ref_regs [NR];
  logic [7:0]   ref_psr;

  alu_seq #(.WIDTH(W), .REGBITS(RB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_src    (instr_src),
    .instr_dst    (instr_dst),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cont     (alu_cont),
    .alu_result   (alu_result),
    .alu_psr      (alu_psr),
    .psr          (psr),
    .done         (done),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ALU behaviour: returns {flags, result}. SUB/CMP compute b - a (dst - src).
  function automatic logic [W+7:0] alu_fn(input logic [3:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0011: r = a ^ b;
      4'b0101: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[W-1:0];
        c    = wide[W];
        v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b1001, 4'b1011: begin
        r = b - a;
        c = (b < a);
        v = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
      end
      4'b1101: r = a;
      default: r = ~(a ^ b);
    endcase
    return {r[W-1], (r == '0), c, v, 4'b0000, r};
  endfunction

  always_comb {alu_psr, alu_result} = alu_fn(alu_cont, alu_a, alu_b);

  // Architectural effect of one instruction on the reference state.
  task automatic model_exec(input logic [3:0] op, input logic [RB-1:0] src,
                            input logic [RB-1:0] dst, input logic imm_en,
                            input logic [7:0] imm);
    logic [W-1:0] a;
    logic [W+7:0] fr;
    a  = imm_en ? {{(W-8){imm[7]}}, imm} : ref_regs[src];
    fr = alu_fn(op, a, ref_regs[dst]);
    if (op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1101, 4'b1001})
      ref_regs[dst] = fr[W-1:0];
    if (op inside {4'b0101, 4'b1001, 4'b1011})
      ref_psr = fr[W+7:W];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ref_regs[i] = '0;
    ref_psr = '0;
  endtask

  // Issues one instruction starting at a negedge with the DUT idle, and
  // records done/illegal/ready at the four following negedges plus the
  // destination register as seen on dbg_data after the commit edge.
  // While busy, instr_* is scrambled (valid held high when hold=1).
  task automatic run_instr(input logic [3:0] op, input logic [RB-1:0] src,
                           input logic [RB-1:0] dst, input logic imm_en,
                           input logic [7:0] imm, input bit hold,
                           output logic [3:0] done_v, output logic [3:0] ill_v,
                           output logic [3:0] rdy_v, output logic [W-1:0] dst_val,
                           output int acc_cycle);
    instr_valid  = 1'b1;
    instr_op     = op;
    instr_src    = src;
    instr_dst    = dst;
    instr_imm_en = imm_en;
    instr_imm    = imm;
    dbg_addr     = dst;
    acc_cycle    = cycle;
    model_exec(op, src, dst, imm_en, imm);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      done_v[k] = done;
      ill_v[k]  = illegal;
      rdy_v[k]  = instr_ready;
      if (k < 3) begin
        instr_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
        instr_op     = 4'($urandom);
        instr_src    = RB'($urandom);
        instr_dst    = RB'($urandom);
        instr_imm_en = 1'($urandom);
        instr_imm    = 8'($urandom);
      end else begin
        dst_val     = dbg_data;
        instr_valid = hold;
      end
    end
  endtask

  task automatic read_reg(input int idx, output logic [W-1:0] v);
    dbg_addr = RB'(idx);
    #1;
    v = dbg_data;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [W-1:0] v;
    reset_n = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_src = '0;
    instr_dst = '0; instr_imm_en = 1'b0; instr_imm = '0; dbg_addr = '0;
    #2 reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 1", instr_ready);
    end
    tests_run++;
    if (psr !== 8'h00) begin
      tests_failed++; $display("FAIL reset_psr: got %h want 00", psr);
    end
    tests_run++;
    if ({done, illegal} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_done_illegal: got %b want 00", {done, illegal});
    end
    tests_run++;
    if ({alu_a, alu_b, alu_cont} !== '0) begin
      tests_failed++; $display("FAIL reset_alu_drive: got a=%h b=%h c=%h want 0", alu_a, alu_b, alu_cont);
    end
    for (int i = 0; i < NR; i++) begin
      read_reg(i, v);
      tests_run++;
      if (v !== '0) begin
        tests_failed++; $display("FAIL reset_reg%0d: got %h want 0000", i, v);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mov_add();
    logic [3:0] d, il, r; logic [W-1:0] v; int ac;
    run_instr(4'b1101, 4'd0, 4'd1, 1'b1, 8'h7F, 1'b0, d, il, r, v, ac);
    tests_run++;
    if (d !== 4'b0100 || r !== 4'b1000) begin
      tests_failed++; $display("FAIL mov_timing: done=%b ready=%b want 0100/1000", d, r);
    end
    tests_run++;
    if (v !== 16'h007F) begin
      tests_failed++; $display("FAIL mov_r1: got %h want 007f", v);
    end
    run_instr(4'b0101, 4'd1, 4'd1, 1'b0, 8'h00, 1'b0, d, il, r, v, ac);
    tests_run++;
    if (d !== 4'b0100 || il !== 4'b0000) begin
      tests_failed++; $display("FAIL add_timing: done=%b illegal=%b want 0100/0000", d, il);
    end
    tests_run++;
    if (v !== 16'h00FE) begin
      tests_failed++; $display("FAIL add_r1: got %h want 00fe", v);
    end
    tests_run++;
    if (psr[7:6] !== 2'b00 || psr !== ref_psr) begin
      tests_failed++; $display("FAIL add_psr: got %h want %h (N=Z=0)", psr, ref_psr);
    end
  endtask

  task automatic test_cmp();
    logic [3:0] d, il, r; logic [W-1:0] v; int ac;
    run_instr(4'b1101, 4'd0, 4'd2, 1'b1, 8'h05, 1'b0, d, il, r, v, ac);
    run_instr(4'b1101, 4'd0, 4'd3, 1'b1, 8'h05, 1'b0, d, il, r, v, ac);
    run_instr(4'b1011, 4'd2, 4'd3, 1'b0, 8'h00, 1'b0, d, il, r, v, ac);
    tests_run++;
    if (v !== 16'h0005) begin
      tests_failed++; $display("FAIL cmp_r3_unchanged: got %h want 0005", v);
    end
    tests_run++;
    if (psr[6] !== 1'b1 || psr !== ref_psr) begin
      tests_failed++; $display("FAIL cmp_psr: got %h want %h (Z=1)", psr, ref_psr);
    end
    run_instr(4'b0001, 4'd2, 4'd3, 1'b0, 8'h00, 1'b0, d, il, r, v, ac);
    tests_run++;
    if (psr !== 8'h40) begin
      tests_failed++; $display("FAIL and_keeps_psr: got %h want 40", psr);
    end
    tests_run++;
    if (v !== 16'h0005) begin
      tests_failed++; $display("FAIL and_r3: got %h want 0005", v);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] d, il, r; logic [W-1:0] v; int ac;
    run_instr(4'b0111, 4'd2, 4'd3, 1'b0, 8'h00, 1'b0, d, il, r, v, ac);
    tests_run++;
    if (d !== 4'b0100 || il !== 4'b0100) begin
      tests_failed++; $display("FAIL illegal_pulse: done=%b illegal=%b want 0100/0100", d, il);
    end
    tests_run++;
    if (v !== ref_regs[3]) begin
      tests_failed++; $display("FAIL illegal_no_write: got %h want %h", v, ref_regs[3]);
    end
    tests_run++;
    if (psr !== ref_psr) begin
      tests_failed++; $display("FAIL illegal_psr: got %h want %h", psr, ref_psr);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d1, d2, d3, il, r; logic [W-1:0] v1, v2, v3; int a1, a2, a3;
    run_instr(4'b1101, 4'd0, 4'd6, 1'b1, 8'h23, 1'b1, d1, il, r, v1, a1);
    run_instr(4'b0101, 4'd6, 4'd6, 1'b0, 8'h00, 1'b1, d2, il, r, v2, a2);
    run_instr(4'b1001, 4'd6, 4'd7, 1'b0, 8'h00, 1'b0, d3, il, r, v3, a3);
    tests_run++;
    if (a2 - a1 != 4 || a3 - a2 != 4) begin
      tests_failed++; $display("FAIL b2b_spacing: got %0d,%0d want 4,4", a2 - a1, a3 - a2);
    end
    tests_run++;
    if ({d1, d2, d3} !== 12'b0100_0100_0100) begin
      tests_failed++; $display("FAIL b2b_done: got %b want 010001000100", {d1, d2, d3});
    end
    tests_run++;
    if (v2 !== 16'h0046) begin
      tests_failed++; $display("FAIL b2b_forward: got %h want 0046", v2);
    end
    tests_run++;
    if (v3 !== ref_regs[7] || psr !== ref_psr) begin
      tests_failed++; $display("FAIL b2b_sub: got r7=%h psr=%h want %h/%h", v3, psr, ref_regs[7], ref_psr);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] d, il, r; logic [W-1:0] v; int ac; logic seen_done;
    run_instr(4'b1101, 4'd0, 4'd4, 1'b1, 8'h34, 1'b0, d, il, r, v, ac);
    run_instr(4'b1101, 4'd0, 4'd5, 1'b1, 8'h12, 1'b0, d, il, r, v, ac);
    for (int i = 0; i < 8; i++)
      run_instr(4'b0101, 4'd5, 4'd5, 1'b0, 8'h00, 1'b0, d, il, r, v, ac);
    run_instr(4'b1011, 4'd5, 4'd5, 1'b0, 8'h00, 1'b0, d, il, r, v, ac);
    tests_run++;
    if (v !== 16'h1200 || psr !== 8'h40) begin
      tests_failed++; $display("FAIL rst_setup: got r5=%h psr=%h want 1200/40", v, psr);
    end
    // ADD R5 into R4 (would give 0x1234); reset while it is in EXEC.
    instr_valid = 1'b1; instr_op = 4'b0101; instr_src = 4'd5; instr_dst = 4'd4;
    instr_imm_en = 1'b0; dbg_addr = 4'd4;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    seen_done = done;
    @(negedge clk);
    seen_done |= done;
    reset_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (psr !== 8'h00 || dbg_data !== '0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL rst_async: psr=%h r4=%h done=%b want 00/0000/0", psr, dbg_data, done);
    end
    repeat (2) begin
      @(negedge clk);
      seen_done |= done;
    end
    reset_n = 1'b1;
    @(negedge clk);
    seen_done |= done;
    tests_run++;
    if (instr_ready !== 1'b1 || seen_done !== 1'b0) begin
      tests_failed++; $display("FAIL rst_release: ready=%b done_seen=%b want 1/0", instr_ready, seen_done);
    end
    tests_run++;
    if (dbg_data !== '0 || psr !== 8'h00) begin
      tests_failed++; $display("FAIL rst_abort: r4=%h psr=%h want 0000/00", dbg_data, psr);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [10];
    logic [3:0] d, il, r, op, exp_il; logic [W-1:0] v; int ac;
    logic [RB-1:0] dst;
    ops = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001,
            4'b1011, 4'b1101, 4'b0111, 4'b0000, 4'b1111};
    for (int n = 0; n < 40; n++) begin
      op  = ops[$urandom_range(0, 9)];
      dst = RB'($urandom);
      run_instr(op, RB'($urandom), dst, 1'($urandom), 8'($urandom), 1'b0,
                d, il, r, v, ac);
      exp_il = (op inside {4'b0111, 4'b0000, 4'b1111}) ? 4'b0100 : 4'b0000;
      tests_run++;
      if (d !== 4'b0100 || il !== exp_il || r !== 4'b1000) begin
        tests_failed++;
        $display("FAIL rand%0d_seq op=%b: done=%b ill=%b rdy=%b want 0100/%b/1000", n, op, d, il, r, exp_il);
      end
      tests_run++;
      if (v !== ref_regs[dst] || psr !== ref_psr) begin
        tests_failed++;
        $display("FAIL rand%0d_state op=%b: r%0d=%h psr=%h want %h/%h", n, op, dst, v, psr, ref_regs[dst], ref_psr);
      end
    end
    for (int i = 0; i < NR; i++) begin
      read_reg(i, v);
      tests_run++;
      if (v !== ref_regs[i]) begin
        tests_failed++; $display("FAIL rand_final_r%0d: got %h want %h", i, v, ref_regs[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mov_add();
    test_cmp();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning datapath and register width.
REQ-002 The block SHALL have parameter REGBITS, default 4, meaning register-index width (2^REGBITS registers).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port instr_valid, input, 1, instruction offered.
REQ-006 The block SHALL have port instr_ready, output, 1, block can accept an instruction.
REQ-007 The block SHALL have port instr_op, input, 4, ALU opcode extension (alucont encoding).
REQ-008 The block SHALL have ports instr_src and instr_dst, input, REGBITS each, source and destination register indices.
REQ-009 The block SHALL have ports instr_imm_en, input, 1, and instr_imm, input, 8, immediate select and immediate value.
REQ-010 The block SHALL have ports alu_a and alu_b, output, WIDTH each, and alu_cont, output, 4; these are registered drives to the external ALU.
REQ-011 The block SHALL have ports alu_result, input, WIDTH, and alu_psr, input, 8, combinational returns from the ALU.
REQ-012 The block SHALL have ports psr, output, 8, the architectural status register, and done, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL have port illegal, output, 1, pulsed together with done for an unsupported opcode.
REQ-014 The block SHALL have ports dbg_addr, input, REGBITS, and dbg_data, output, WIDTH, a combinational read of register dbg_addr.

Function
REQ-015 Legal opcodes SHALL be AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101; all others are illegal.
REQ-016 The FSM SHALL have states IDLE, READ, EXEC, WB; instr_ready=1 only in IDLE.
REQ-017 In IDLE, instr_valid&&instr_ready at edge E0 SHALL capture all instr_* fields and move to READ; without valid the FSM stays in IDLE.
REQ-018 At edge E1 (READ->EXEC) the block SHALL load alu_a = sign-extended instr_imm if imm_en else R[src], alu_b = R[dst], alu_cont = op.
REQ-019 At edge E2 (EXEC->WB) the block SHALL sample alu_result and alu_psr into internal holding registers.
REQ-020 In WB, done SHALL be 1 for exactly one cycle; at edge E3 (WB->IDLE) the commit SHALL occur.
REQ-021 Commit: R[dst] SHALL be written with the held result for all legal ops except CMP.
REQ-022 Commit: psr SHALL be loaded from held alu_psr only for ADD, SUB, CMP; AND, OR, XOR, MOV leave psr unchanged.
REQ-023 An illegal opcode SHALL sequence identically but assert illegal with done and perform no register or psr write.
REQ-024 Latency SHALL be fixed: done in the 3rd cycle after acceptance; next acceptance no earlier than edge E4; throughput one instruction per 4 cycles.
REQ-025 src==dst SHALL read the pre-commit value for both operands.
REQ-026 A commit at E3 SHALL be visible to a following instruction's READ.
REQ-027 A commit SHALL be visible on dbg_data in the cycle after E3.
REQ-028 instr_* changes while not in IDLE SHALL be ignored.
REQ-029 alu_a, alu_b and alu_cont SHALL hold their values from E1 until the next E1.

Reset
REQ-030 While reset_n=0 the block SHALL force state IDLE, all registers R[0..2^REGBITS-1]=0, psr=0, alu_a=alu_b=0, alu_cont=0, and done=illegal=0, immediately and asynchronously.
REQ-031 Reset asserted mid-instruction SHALL abort it with no register or psr write; instr_ready=1 from the first cycle after release.

Structure
REQ-032 Shared package alu_seq_pkg SHALL hold the opcode constants, the state enumeration, and default WIDTH/REGBITS.
REQ-033 The register file SHALL be one sub-module, alu_seq_regfile: 2 combinational read ports plus the debug read port, 1 synchronous write port, async reset.

Verification
REQ-034 Bench SHALL check: after reset, dbg_data=0 for all addresses, psr=0, instr_ready=1.
REQ-035 Bench SHALL check: MOV imm 0x7F->R1, then ADD R1,R1 with ALU model -> R1=0x00FE, psr N=Z=0, done in the 3rd cycle after each accept.
REQ-036 Bench SHALL check: R2=R3=0x0005, CMP src R2 dst R3 -> R3 unchanged, psr Z=1; following AND -> psr still Z=1.
REQ-037 Bench SHALL check: opcode 0111 -> illegal and done pulse together, no register change, psr unchanged.
REQ-038 Bench SHALL check: back-to-back with instr_valid held high -> accepts exactly every 4 cycles; second instruction reads first's commit.
REQ-039 Bench SHALL check: reset_n low in EXEC of an ADD to R4=0x1234 -> R4=0, psr=0, no done, IDLE after release.
